fft_ctrl_reg_bank: RTL and testbench
====================================

Name: fft_ctrl_reg_bank

Overview:
Responder end of the scan-side control register channels (pnt_cfg, cycle_cfg, start_fft, reset_fft). It accepts ren/wen/wdata requests from the group scan memory/register interface and returns rdata and ready. It holds the FFT configuration, generates the start pulse and timed soft reset for the FFT core, and tracks busy/done status.

Parameters:
PNT_W, 3, point-config width
CYC_W, 11, cycle-config width
DEFAULT_PNT, 0, pnt_cfg reset value
DEFAULT_CYC, 0, cycle_cfg reset value
MAX_PNT_CODE, 5, largest legal point code; larger writes saturate to this value
RESET_CYCLES, 4, soft-reset low duration in clk cycles (>=1)

Ports:
clk  in  1  block clock
rst_n  in  1  asynchronous active-low reset
pnt_cfg_ren / pnt_cfg_wen  in  1 each  point-config read / write request
pnt_cfg_wdata  in  PNT_W  write data
pnt_cfg_rdata  out  PNT_W  read data
pnt_cfg_ready  out  1  one-cycle acknowledge
cycle_cfg_ren / cycle_cfg_wen / cycle_cfg_wdata(CYC_W) / cycle_cfg_rdata(CYC_W) / cycle_cfg_ready  same roles as the point-config channel
start_fft_ren / start_fft_wen / start_fft_wdata(1) / start_fft_rdata(1) / start_fft_ready  same roles
reset_fft_ren / reset_fft_wen / reset_fft_wdata(1) / reset_fft_rdata(1) / reset_fft_ready  same roles
fft_done  in  1  core completion pulse/level
cfg_points  out  PNT_W  applied point code
cfg_cycles  out  CYC_W  applied cycle count
fft_start  out  1  one-cycle start pulse to core
fft_soft_rst_n  out  1  core soft reset, active low
fft_busy  out  1  run in progress
done_sticky  out  1  latched completion

Behaviour:
- Reset values: all rdata 0, all ready 0, cfg_points=DEFAULT_PNT, cfg_cycles=DEFAULT_CYC, fft_start=0, fft_soft_rst_n=1, fft_busy=0, done_sticky=0. Every channel FSM is in IDLE.
- Per-channel handshake FSM with states IDLE, ACK, RELEASE:
  - IDLE: if ren|wen is sampled high in cycle N, the access executes in N and the FSM goes to ACK.
  - ACK: ready=1 for exactly cycle N+1; rdata becomes valid in the same cycle. Next state is RELEASE if ren|wen is still high, else IDLE.
  - RELEASE: wait until ren and wen are both low, then go to IDLE. A held request therefore never re-executes.
- ren and wen together: the write executes and rdata returns the post-write value.
- rdata is registered and holds its value between transactions.
- pnt_cfg write: stores min(wdata, MAX_PNT_CODE). rdata = cfg_points.
- cycle_cfg write: stores wdata unchanged. rdata = cfg_cycles.
- start_fft write with wdata=1:
  - Accepted only if !fft_busy and fft_soft_rst_n=1.
  - On acceptance: fft_start=1 in cycle N+1, fft_busy=1 from N+1, done_sticky cleared.
  - Otherwise the write is ignored; ready is still returned.
  - wdata=0 has no effect. rdata = fft_busy.
- reset_fft write with wdata=1:
  - Loads a down-counter with RESET_CYCLES; fft_soft_rst_n=0 from N+1 for exactly RESET_CYCLES cycles.
  - Clears fft_busy and done_sticky.
  - A write while the counter is running reloads it, extending the low time.
  - rdata = ~fft_soft_rst_n.
- fft_done:
  - Sampled high while fft_busy: fft_busy=0 next cycle, done_sticky=1.
  - Ignored while !fft_busy or during soft reset.
  - fft_done and an accepted start in the same cycle: the start wins.
- Channels are independent; simultaneous requests on all four channels complete in parallel.
- rst_n asserted mid-transaction: everything returns to reset values immediately, and any pending ready is dropped.

Optional Feature:
FFT_CFG_LOCK_EN
- Defined: pnt_cfg and cycle_cfg writes are ignored while fft_busy=1; ready is still returned and rdata shows the unchanged value.
- Undefined: config writes always take effect, and the core sees the new value immediately.

Decomposition:
- Package fft_ctrl_pkg: PNT_W and CYC_W defaults, the channel state enum chan_state_t {IDLE, ACK, RELEASE}, and a reset-counter width localparam.
- Sub-module fft_reg_chan_hs: the per-channel handshake FSM. It takes ren/wen and produces an exec strobe and ready; it is instantiated four times.
- Register and status logic stays in the top.

Test Plan:
- Write pnt_cfg=3, hold wen for 5 cycles -> ready high exactly one cycle (N+1), one write only, cfg_points=3; read back gives rdata=3.
- Write pnt_cfg=7 -> cfg_points=5 (saturation).
- Write start_fft=1 -> fft_start pulse at N+1, fft_busy=1. A second start while busy -> no pulse. Then fft_done -> fft_busy=0, done_sticky=1; read start_fft gives rdata=0.
- Write reset_fft=1 with RESET_CYCLES=4 -> fft_soft_rst_n low for 4 cycles. Rewrite at the 2nd low cycle -> low extends to 6 cycles total; a start during the low period is ignored.
- ren and wen together on cycle_cfg with wdata=11'h2AB -> ready at N+1 with rdata=11'h2AB.
- With FFT_CFG_LOCK_EN defined, write cycle_cfg=100 while busy -> cfg_cycles unchanged, ready still returned.
- Assert rst_n low while in ACK -> ready=0 and all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared widths, channel indices and handshake state encoding for the FFT control register bank.
package fft_ctrl_pkg;
    localparam int PNT_W_DEF = 3;
    localparam int CYC_W_DEF = 11;
    // Soft-reset down-counter width; covers RESET_CYCLES up to 255.
    localparam int RST_CNT_W = 8;

    localparam int NUM_CH = 4;
    localparam int CH_PNT = 0;
    localparam int CH_CYC = 1;
    localparam int CH_STA = 2;
    localparam int CH_RST = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        RELEASE
    } chan_state_t;
endpackage

// File: rtl/fft_reg_chan_hs.sv
// Per-channel request/acknowledge FSM: one exec strobe per request, one-cycle ready,
// and a held request never re-executes until ren and wen both drop.
module fft_reg_chan_hs
    import fft_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ren_i,
    input  logic wen_i,
    output logic exec_o,
    output logic ready_o
);

    chan_state_t state_q, state_d;
    logic        req;

    assign req = ren_i | wen_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        exec_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    exec_o  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = req ? RELEASE : IDLE;
            RELEASE: if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded from state so an async reset drops a pending acknowledge at once.
    assign ready_o = (state_q == ACK);

endmodule

// File: rtl/fft_ctrl_reg_bank.sv
// FFT control register bank: point/cycle config, start pulse, timed soft reset, busy/done status.
// Optional build macro FFT_CFG_LOCK_EN: freeze pnt_cfg/cycle_cfg writes while a run is busy.
module fft_ctrl_reg_bank
    import fft_ctrl_pkg::*;
#(
    parameter int PNT_W        = PNT_W_DEF,
    parameter int CYC_W        = CYC_W_DEF,
    parameter int DEFAULT_PNT  = 0,
    parameter int DEFAULT_CYC  = 0,
    parameter int MAX_PNT_CODE = 5,
    parameter int RESET_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pnt_cfg_ren,
    input  logic             pnt_cfg_wen,
    input  logic [PNT_W-1:0] pnt_cfg_wdata,
    output logic [PNT_W-1:0] pnt_cfg_rdata,
    output logic             pnt_cfg_ready,
    input  logic             cycle_cfg_ren,
    input  logic             cycle_cfg_wen,
    input  logic [CYC_W-1:0] cycle_cfg_wdata,
    output logic [CYC_W-1:0] cycle_cfg_rdata,
    output logic             cycle_cfg_ready,
    input  logic             start_fft_ren,
    input  logic             start_fft_wen,
    input  logic             start_fft_wdata,
    output logic             start_fft_rdata,
    output logic             start_fft_ready,
    input  logic             reset_fft_ren,
    input  logic             reset_fft_wen,
    input  logic             reset_fft_wdata,
    output logic             reset_fft_rdata,
    output logic             reset_fft_ready,
    input  logic             fft_done,
    output logic [PNT_W-1:0] cfg_points,
    output logic [CYC_W-1:0] cfg_cycles,
    output logic             fft_start,
    output logic             fft_soft_rst_n,
    output logic             fft_busy,
    output logic             done_sticky
);

    localparam logic [PNT_W-1:0]     MAX_PNT  = PNT_W'(MAX_PNT_CODE);
    localparam logic [PNT_W-1:0]     RST_PNT  = PNT_W'(DEFAULT_PNT);
    localparam logic [CYC_W-1:0]     RST_CYC  = CYC_W'(DEFAULT_CYC);
    localparam logic [RST_CNT_W-1:0] RST_LOAD = RST_CNT_W'(RESET_CYCLES);

    logic [NUM_CH-1:0] ren_v, wen_v, exec_v, ready_v;

    assign ren_v = {reset_fft_ren, start_fft_ren, cycle_cfg_ren, pnt_cfg_ren};
    assign wen_v = {reset_fft_wen, start_fft_wen, cycle_cfg_wen, pnt_cfg_wen};

    fft_reg_chan_hs u_hs [NUM_CH-1:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .ren_i   (ren_v),
        .wen_i   (wen_v),
        .exec_o  (exec_v),
        .ready_o (ready_v)
    );

    assign pnt_cfg_ready   = ready_v[CH_PNT];
    assign cycle_cfg_ready = ready_v[CH_CYC];
    assign start_fft_ready = ready_v[CH_STA];
    assign reset_fft_ready = ready_v[CH_RST];

    logic [PNT_W-1:0]     pnt_q, pnt_d, pnt_rd_q;
    logic [CYC_W-1:0]     cyc_q, cyc_d, cyc_rd_q;
    logic [RST_CNT_W-1:0] cnt_q, cnt_d;
    logic                 srst_n_q, srst_n_d;
    logic                 busy_q, busy_d;
    logic                 sticky_q, sticky_d;
    logic                 start_q;
    logic                 sta_rd_q, rst_rd_q;
    logic                 cfg_lock;
    logic                 rst_wr, start_acc, done_hit;

`ifdef FFT_CFG_LOCK_EN
    assign cfg_lock = busy_q;
`else
    assign cfg_lock = 1'b0;
`endif

    // A reset write in the same cycle as a start wins; the start is dropped.
    assign rst_wr    = exec_v[CH_RST] & reset_fft_wen & reset_fft_wdata;
    assign start_acc = exec_v[CH_STA] & start_fft_wen & start_fft_wdata
                       & ~busy_q & srst_n_q & ~rst_wr;
    assign done_hit  = fft_done & busy_q & srst_n_q;

    always_comb begin
        pnt_d    = pnt_q;
        cyc_d    = cyc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        sticky_d = sticky_q;

        if (exec_v[CH_PNT] && pnt_cfg_wen && !cfg_lock)
            pnt_d = (pnt_cfg_wdata > MAX_PNT) ? MAX_PNT : pnt_cfg_wdata;
        if (exec_v[CH_CYC] && cycle_cfg_wen && !cfg_lock)
            cyc_d = cycle_cfg_wdata;

        if (rst_wr)          cnt_d = RST_LOAD;
        else if (cnt_q != 0) cnt_d = cnt_q - 1'b1;

        // Start beats a same-cycle done: the new run is what the core sees.
        if (rst_wr) begin
            busy_d   = 1'b0;
            sticky_d = 1'b0;
        end else if (start_acc) begin
            busy_d   = 1'b1;
            sticky_d = 1'b0;
        end else if (done_hit) begin
            busy_d   = 1'b0;
            sticky_d = 1'b1;
        end

        srst_n_d = (cnt_d == 0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pnt_q    <= RST_PNT;
            cyc_q    <= RST_CYC;
            cnt_q    <= '0;
            srst_n_q <= 1'b1;
            busy_q   <= 1'b0;
            sticky_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            pnt_q    <= pnt_d;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            srst_n_q <= srst_n_d;
            busy_q   <= busy_d;
            sticky_q <= sticky_d;
            start_q  <= start_acc;
        end
    end

    // Read data captures the post-write value and holds until the next access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pnt_rd_q <= '0;
            cyc_rd_q <= '0;
            sta_rd_q <= 1'b0;
            rst_rd_q <= 1'b0;
        end else begin
            if (exec_v[CH_PNT]) pnt_rd_q <= pnt_d;
            if (exec_v[CH_CYC]) cyc_rd_q <= cyc_d;
            if (exec_v[CH_STA]) sta_rd_q <= busy_d;
            if (exec_v[CH_RST]) rst_rd_q <= ~srst_n_d;
        end
    end

    assign pnt_cfg_rdata   = pnt_rd_q;
    assign cycle_cfg_rdata = cyc_rd_q;
    assign start_fft_rdata = sta_rd_q;
    assign reset_fft_rdata = rst_rd_q;
    assign cfg_points      = pnt_q;
    assign cfg_cycles      = cyc_q;
    assign fft_start       = start_q;
    assign fft_soft_rst_n  = srst_n_q;
    assign fft_busy        = busy_q;
    assign done_sticky     = sticky_q;

endmodule

// File: tb/tb_fft_ctrl_reg_bank.sv
// Directed bench for fft_ctrl_reg_bank; lock-dependent expectations follow FFT_CFG_LOCK_EN.
module tb_fft_ctrl_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pnt_cfg_ren, pnt_cfg_wen, pnt_cfg_ready;
    logic [2:0]  pnt_cfg_wdata, pnt_cfg_rdata;
    logic        cycle_cfg_ren, cycle_cfg_wen, cycle_cfg_ready;
    logic [10:0] cycle_cfg_wdata, cycle_cfg_rdata;
    logic        start_fft_ren, start_fft_wen, start_fft_wdata, start_fft_rdata, start_fft_ready;
    logic        reset_fft_ren, reset_fft_wen, reset_fft_wdata, reset_fft_rdata, reset_fft_ready;
    logic        fft_done;
    logic [2:0]  cfg_points;
    logic [10:0] cfg_cycles;
    logic        fft_start, fft_soft_rst_n, fft_busy, done_sticky;

    int n_cmp = 0;
    int n_fail = 0;

    fft_ctrl_reg_bank dut (
        .clk(clk), .rst_n(rst_n),
        .pnt_cfg_ren(pnt_cfg_ren), .pnt_cfg_wen(pnt_cfg_wen), .pnt_cfg_wdata(pnt_cfg_wdata),
        .pnt_cfg_rdata(pnt_cfg_rdata), .pnt_cfg_ready(pnt_cfg_ready),
        .cycle_cfg_ren(cycle_cfg_ren), .cycle_cfg_wen(cycle_cfg_wen), .cycle_cfg_wdata(cycle_cfg_wdata),
        .cycle_cfg_rdata(cycle_cfg_rdata), .cycle_cfg_ready(cycle_cfg_ready),
        .start_fft_ren(start_fft_ren), .start_fft_wen(start_fft_wen), .start_fft_wdata(start_fft_wdata),
        .start_fft_rdata(start_fft_rdata), .start_fft_ready(start_fft_ready),
        .reset_fft_ren(reset_fft_ren), .reset_fft_wen(reset_fft_wen), .reset_fft_wdata(reset_fft_wdata),
        .reset_fft_rdata(reset_fft_rdata), .reset_fft_ready(reset_fft_ready),
        .fft_done(fft_done),
        .cfg_points(cfg_points), .cfg_cycles(cfg_cycles), .fft_start(fft_start),
        .fft_soft_rst_n(fft_soft_rst_n), .fft_busy(fft_busy), .done_sticky(done_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_run();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_cmp++; if (pnt_cfg_ready !== 1'b0 || cycle_cfg_ready !== 1'b0 || start_fft_ready !== 1'b0 || reset_fft_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b%b%b%b want 0000", pnt_cfg_ready, cycle_cfg_ready, start_fft_ready, reset_fft_ready); end
        n_cmp++; if (pnt_cfg_rdata !== 3'd0 || cycle_cfg_rdata !== 11'd0 || start_fft_rdata !== 1'b0 || reset_fft_rdata !== 1'b0) begin n_fail++; $display("FAIL rst_rdata got %h %h %b %b want 0", pnt_cfg_rdata, cycle_cfg_rdata, start_fft_rdata, reset_fft_rdata); end
        n_cmp++; if ({cfg_points, cfg_cycles} !== 14'd0) begin n_fail++; $display("FAIL rst_cfg got %h %h want 0 0", cfg_points, cfg_cycles); end
        n_cmp++; if ({fft_start, fft_soft_rst_n, fft_busy, done_sticky} !== 4'b0100) begin n_fail++; $display("FAIL rst_status got %b%b%b%b want 0100", fft_start, fft_soft_rst_n, fft_busy, done_sticky); end
    endtask

    task automatic test_pnt_hold();
        int rdy = 0;
        pnt_cfg_wdata = 3'd3; pnt_cfg_wen = 1'b1;
        tick();
        n_cmp++; if (pnt_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL pnt_ready_n1 got %b want 1", pnt_cfg_ready); end
        rdy = 1;
        pnt_cfg_wdata = 3'd4;
        for (int i = 0; i < 4; i++) begin tick(); if (pnt_cfg_ready) rdy++; end
        pnt_cfg_wen = 1'b0;
        for (int i = 0; i < 2; i++) begin tick(); if (pnt_cfg_ready) rdy++; end
        n_cmp++; if (rdy !== 1) begin n_fail++; $display("FAIL pnt_ready_count got %0d want 1", rdy); end
        n_cmp++; if (cfg_points !== 3'd3) begin n_fail++; $display("FAIL pnt_single_write got %0d want 3", cfg_points); end
        pnt_cfg_ren = 1'b1;
        tick();
        n_cmp++; if (pnt_cfg_ready !== 1'b1 || pnt_cfg_rdata !== 3'd3) begin n_fail++; $display("FAIL pnt_read got rdy=%b rdata=%0d want 1/3", pnt_cfg_ready, pnt_cfg_rdata); end
        pnt_cfg_ren = 1'b0;
        tick();
    endtask

    task automatic test_pnt_sat();
        pnt_cfg_wdata = 3'd7; pnt_cfg_wen = 1'b1;
        tick();
        pnt_cfg_wen = 1'b0;
        n_cmp++; if (cfg_points !== 3'd5 || pnt_cfg_rdata !== 3'd5) begin n_fail++; $display("FAIL pnt_sat got %0d rdata %0d want 5", cfg_points, pnt_cfg_rdata); end
        tick();
        pnt_cfg_wdata = 3'd5; pnt_cfg_wen = 1'b1;
        tick();
        pnt_cfg_wen = 1'b0;
        n_cmp++; if (cfg_points !== 3'd5) begin n_fail++; $display("FAIL pnt_max got %0d want 5", cfg_points); end
        tick();
    endtask

    task automatic test_start_done();
        start_fft_wdata = 1'b1; start_fft_wen = 1'b1;
        tick();
        start_fft_wen = 1'b0;
        n_cmp++; if (fft_start !== 1'b1 || fft_busy !== 1'b1 || start_fft_ready !== 1'b1) begin n_fail++; $display("FAIL start_accept got start=%b busy=%b rdy=%b want 111", fft_start, fft_busy, start_fft_ready); end
        tick();
        n_cmp++; if (fft_start !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width got %b want 0", fft_start); end
        start_fft_wen = 1'b1;
        tick();
        start_fft_wen = 1'b0;
        n_cmp++; if (fft_start !== 1'b0 || fft_busy !== 1'b1 || start_fft_ready !== 1'b1) begin n_fail++; $display("FAIL start_busy_ignored got start=%b busy=%b rdy=%b want 011", fft_start, fft_busy, start_fft_ready); end
        tick();
        finish_run();
        n_cmp++; if (fft_busy !== 1'b0 || done_sticky !== 1'b1) begin n_fail++; $display("FAIL done got busy=%b sticky=%b want 0/1", fft_busy, done_sticky); end
        start_fft_ren = 1'b1;
        tick();
        start_fft_ren = 1'b0;
        n_cmp++; if (start_fft_rdata !== 1'b0 || start_fft_ready !== 1'b1) begin n_fail++; $display("FAIL start_read got rdata=%b rdy=%b want 0/1", start_fft_rdata, start_fft_ready); end
        tick();
        // start and done in the same cycle: start wins, sticky clears
        start_fft_wen = 1'b1; fft_done = 1'b1;
        tick();
        start_fft_wen = 1'b0; fft_done = 1'b0;
        n_cmp++; if (fft_start !== 1'b1 || fft_busy !== 1'b1 || done_sticky !== 1'b0) begin n_fail++; $display("FAIL start_vs_done got start=%b busy=%b sticky=%b want 110", fft_start, fft_busy, done_sticky); end
        tick();
        finish_run();
    endtask

    task automatic test_soft_reset();
        int lows = 0;
        reset_fft_wdata = 1'b1; reset_fft_wen = 1'b1;
        tick();
        reset_fft_wen = 1'b0;
        n_cmp++; if (reset_fft_rdata !== 1'b1 || done_sticky !== 1'b0) begin n_fail++; $display("FAIL srst_rdata got rdata=%b sticky=%b want 1/0", reset_fft_rdata, done_sticky); end
        if (!fft_soft_rst_n) lows++;
        for (int i = 0; i < 8; i++) begin tick(); if (!fft_soft_rst_n) lows++; end
        n_cmp++; if (lows !== 4) begin n_fail++; $display("FAIL srst_len got %0d want 4", lows); end
        lows = 0;
        reset_fft_wen = 1'b1;
        tick();
        reset_fft_wen = 1'b0;
        if (!fft_soft_rst_n) lows++;
        tick();
        if (!fft_soft_rst_n) lows++;
        reset_fft_wen = 1'b1; start_fft_wdata = 1'b1; start_fft_wen = 1'b1;
        tick();
        reset_fft_wen = 1'b0; start_fft_wen = 1'b0;
        n_cmp++; if (fft_start !== 1'b0 || fft_busy !== 1'b0) begin n_fail++; $display("FAIL srst_start_blocked got start=%b busy=%b want 00", fft_start, fft_busy); end
        if (!fft_soft_rst_n) lows++;
        for (int i = 0; i < 8; i++) begin tick(); if (!fft_soft_rst_n) lows++; end
        n_cmp++; if (lows !== 6) begin n_fail++; $display("FAIL srst_extend got %0d want 6", lows); end
    endtask

    task automatic test_rw_same();
        cycle_cfg_wdata = 11'h2AB; cycle_cfg_wen = 1'b1; cycle_cfg_ren = 1'b1;
        tick();
        cycle_cfg_wen = 1'b0; cycle_cfg_ren = 1'b0;
        n_cmp++; if (cycle_cfg_ready !== 1'b1 || cycle_cfg_rdata !== 11'h2AB || cfg_cycles !== 11'h2AB) begin n_fail++; $display("FAIL rw_same got rdy=%b rdata=%h cyc=%h want 1/2ab/2ab", cycle_cfg_ready, cycle_cfg_rdata, cfg_cycles); end
        tick();
        n_cmp++; if (cycle_cfg_ready !== 1'b0 || cycle_cfg_rdata !== 11'h2AB) begin n_fail++; $display("FAIL rdata_hold got rdy=%b rdata=%h want 0/2ab", cycle_cfg_ready, cycle_cfg_rdata); end
    endtask

    task automatic test_back_to_back();
        pnt_cfg_wdata = 3'd2; pnt_cfg_wen = 1'b1;
        cycle_cfg_wdata = 11'd77; cycle_cfg_wen = 1'b1;
        start_fft_wdata = 1'b1; start_fft_wen = 1'b1;
        reset_fft_ren = 1'b1;
        tick();
        pnt_cfg_wen = 1'b0; cycle_cfg_wen = 1'b0; start_fft_wen = 1'b0; reset_fft_ren = 1'b0;
        n_cmp++; if ({pnt_cfg_ready, cycle_cfg_ready, start_fft_ready, reset_fft_ready} !== 4'b1111) begin n_fail++; $display("FAIL par_ready got %b%b%b%b want 1111", pnt_cfg_ready, cycle_cfg_ready, start_fft_ready, reset_fft_ready); end
        n_cmp++; if (cfg_points !== 3'd2 || cfg_cycles !== 11'd77 || fft_start !== 1'b1 || start_fft_rdata !== 1'b1 || reset_fft_rdata !== 1'b0) begin n_fail++; $display("FAIL par_values got pnt=%0d cyc=%0d start=%b srd=%b rrd=%b want 2/77/1/1/0", cfg_points, cfg_cycles, fft_start, start_fft_rdata, reset_fft_rdata); end
        tick();
    endtask

    task automatic test_cfg_lock();
        logic [10:0] exp_cyc;
`ifdef FFT_CFG_LOCK_EN
        exp_cyc = 11'd77;
`else
        exp_cyc = 11'd100;
`endif
        cycle_cfg_wdata = 11'd100; cycle_cfg_wen = 1'b1;
        tick();
        cycle_cfg_wen = 1'b0;
        n_cmp++; if (fft_busy !== 1'b1 || cycle_cfg_ready !== 1'b1 || cfg_cycles !== exp_cyc || cycle_cfg_rdata !== exp_cyc) begin n_fail++; $display("FAIL cfg_lock got busy=%b rdy=%b cyc=%0d rdata=%0d want 1/1/%0d", fft_busy, cycle_cfg_ready, cfg_cycles, cycle_cfg_rdata, exp_cyc); end
        tick();
    endtask

    task automatic test_async_reset();
        pnt_cfg_wdata = 3'd4; pnt_cfg_wen = 1'b1;
        tick();
        pnt_cfg_wen = 1'b0;
        n_cmp++; if (pnt_cfg_ready !== 1'b1 || fft_busy !== 1'b1) begin n_fail++; $display("FAIL pre_arst got rdy=%b busy=%b want 1/1", pnt_cfg_ready, fft_busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (pnt_cfg_ready !== 1'b0 || pnt_cfg_rdata !== 3'd0 || cfg_points !== 3'd0 || cfg_cycles !== 11'd0) begin n_fail++; $display("FAIL arst_chan got rdy=%b rdata=%0d pnt=%0d cyc=%0d want 0", pnt_cfg_ready, pnt_cfg_rdata, cfg_points, cfg_cycles); end
        n_cmp++; if ({fft_start, fft_soft_rst_n, fft_busy, done_sticky} !== 4'b0100) begin n_fail++; $display("FAIL arst_status got %b%b%b%b want 0100", fft_start, fft_soft_rst_n, fft_busy, done_sticky); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        pnt_cfg_ren = 0; pnt_cfg_wen = 0; pnt_cfg_wdata = 0;
        cycle_cfg_ren = 0; cycle_cfg_wen = 0; cycle_cfg_wdata = 0;
        start_fft_ren = 0; start_fft_wen = 0; start_fft_wdata = 0;
        reset_fft_ren = 0; reset_fft_wen = 0; reset_fft_wdata = 0;
        fft_done = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_pnt_hold();
        test_pnt_sat();
        test_start_done();
        test_soft_reset();
        test_rw_same();
        test_back_to_back();
        test_cfg_lock();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
